mc_control_unit: RTL and testbench

- Multicycle control FSM for the ARM-subset processor; the counterpart of the datapath.
- Consumes the latched instruction and the live ALU flags from the datapath.
- Drives every datapath enable and select, plus MemWrite to the shared instruction/data memory.
- Holds the architectural NZCV flags register and evaluates conditional execution.

---
 rtl/mc_ctrl_pkg.sv | 96 +++++++++
 rtl/mc_control_unit_cond_unit.sv | 57 +++++
 rtl/mc_control_unit.sv | 165 ++++++++++++++++
 tb/tb_mc_control_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit.
// Holds the FSM state enum, instruction field codes, ALU operation codes,
// datapath mux-select codes and the data-processing command decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    // Op field, Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Data-processing cmd field, Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_PCBR = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       writeback;
        logic       nz_wr;
        logic       cv_wr;
        logic       is_cmp;
    } dp_dec_t;

    // Unsupported commands fall through as a NOP: ADD encoding on the ALU,
    // but no register writeback and no flag update.
    function automatic dp_dec_t decode_cmd(input logic [3:0] cmd);
        dp_dec_t d;
        d.alu_ctrl  = ALU_ADD;
        d.writeback = 1'b0;
        d.nz_wr     = 1'b0;
        d.cv_wr     = 1'b0;
        d.is_cmp    = 1'b0;
        case (cmd)
            CMD_ADD: begin
                d.alu_ctrl = ALU_ADD; d.writeback = 1'b1; d.nz_wr = 1'b1; d.cv_wr = 1'b1;
            end
            CMD_SUB: begin
                d.alu_ctrl = ALU_SUB; d.writeback = 1'b1; d.nz_wr = 1'b1; d.cv_wr = 1'b1;
            end
            CMD_CMP: begin
                d.alu_ctrl = ALU_SUB; d.nz_wr = 1'b1; d.cv_wr = 1'b1; d.is_cmp = 1'b1;
            end
            CMD_AND: begin
                d.alu_ctrl = ALU_AND; d.writeback = 1'b1; d.nz_wr = 1'b1;
            end
            CMD_ORR: begin
                d.alu_ctrl = ALU_ORR; d.writeback = 1'b1; d.nz_wr = 1'b1;
            end
            CMD_EOR: begin
                d.alu_ctrl = ALU_EOR; d.writeback = 1'b1; d.nz_wr = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_unit_cond_unit.sv
// Architectural NZCV flags register and condition evaluation.
//   clk, reset    : system clock, synchronous active-low reset
//   cond_i        : Instr[31:28]
//   alu_flags_i   : live {N,Z,C,V} from the ALU
//   flag_wr_i     : {update N/Z, update C/V} requested by the FSM
//   cond_ex_o     : instruction condition passes against the flags register
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_wr_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            4'b0000: cond_ex_o = z;
            4'b0001: cond_ex_o = ~z;
            4'b0010: cond_ex_o = c;
            4'b0011: cond_ex_o = ~c;
            4'b0100: cond_ex_o = n;
            4'b0101: cond_ex_o = ~n;
            4'b0110: cond_ex_o = v;
            4'b0111: cond_ex_o = ~v;
            4'b1000: cond_ex_o = c & ~z;
            4'b1001: cond_ex_o = ~c | z;
            4'b1010: cond_ex_o = (n == v);
            4'b1011: cond_ex_o = (n != v);
            4'b1100: cond_ex_o = ~z & (n == v);
            4'b1101: cond_ex_o = z | (n != v);
            4'b1110: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

    // A failed condition suppresses the flag update as well as the writeback.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex_o && flag_wr_i[1]) flags_d[3:2] = alu_flags_i[3:2];
        if (cond_ex_o && flag_wr_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM and instruction decoder for the ARM-subset core.
// Inputs : clk, reset (sync, active-low), Instr (latched IR), ALUFlags (live NZCV).
// Outputs: datapath enables (PCWrite, MemWrite, RegWrite, IRWrite) and
//          selects (AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl).
//
// state    | meaning
// ---------+-------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | read register file, compute PC+8
// MEMADR   | compute load/store address (base + imm12)
// MEMRD    | read data memory
// MEMWB    | write loaded data to Rd (PC if Rd=15)
// MEMWR    | write store data to memory
// EXECUTER | data-processing, register operand
// EXECUTEI | data-processing, immediate operand
// ALUWB    | write ALU result to Rd (PC if Rd=15)
// BRANCH   | PC <= PC+8+imm24
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    state_e     state_q, state_d;
    logic [1:0] op;
    logic       funct_i;
    logic [3:0] cmd;
    logic       s_l;
    logic       rd_is_pc;
    dp_dec_t    dec;
    logic       cond_ex;
    logic [1:0] flag_req;
    logic       pc_wr, mem_wr, reg_wr, ir_wr;
    logic       unused_instr;

    assign op       = Instr[27:26];
    assign funct_i  = Instr[25];
    assign cmd      = Instr[24:21];
    assign s_l      = Instr[20];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign dec      = decode_cmd(cmd);

    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond_i      (Instr[31:28]),
        .alu_flags_i (ALUFlags),
        .flag_wr_i   (flag_req),
        .cond_ex_o   (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pc_wr      = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        ir_wr      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        flag_req   = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                case (op)
                    OP_DP:   state_d = funct_i ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = s_l ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWR: begin
                AdrSrc  = 1'b1;
                mem_wr  = cond_ex;
                state_d = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_wr    = cond_ex;
                pc_wr     = cond_ex & rd_is_pc;
                state_d   = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcB    = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
                ALUControl = dec.alu_ctrl;
                // CMP always sets flags; others only with S=1.
                if (s_l || dec.is_cmp) flag_req = {dec.nz_wr, dec.cv_wr};
                state_d = dec.is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_wr    = cond_ex & dec.writeback;
                pc_wr     = cond_ex & dec.writeback & rd_is_pc;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_PCBR;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                pc_wr     = cond_ex;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_DP;
        case (op)
            OP_MEM:  ImmSrc = IMM_MEM;
            OP_BR:   ImmSrc = IMM_BR;
            default: ImmSrc = IMM_DP;
        endcase
    end

    assign RegSrc = {(op == OP_MEM) & ~s_l, (op == OP_BR)};

    // No write may land while reset is held, even mid-instruction.
    assign PCWrite  = pc_wr  & reset;
    assign MemWrite = mem_wr & reset;
    assign RegWrite = reg_wr & reset;
    assign IRWrite  = ir_wr  & reset;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
    logic [17:0] obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    typedef struct {
        logic [17:0] vec;
        string       tag;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] m_flags;

    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7, AWB = 8, BR = 9;

    function automatic logic [17:0] pack(input logic pcw, input logic mw, input logic rw,
                                         input logic irw, input logic adr, input logic [1:0] rs,
                                         input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [1:0] res, input logic [1:0] imm,
                                         input logic [2:0] alu);
        return {pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, alu};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // kind: 0 = NOP, 1 = arithmetic (all flags), 2 = logical (N,Z only)
    function automatic int cmd_kind(input logic [3:0] cmd);
        case (cmd)
            4'b0100, 4'b0010, 4'b1010: return 1;
            4'b0000, 4'b1100, 4'b0001: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 3'b001;
            4'b0000:          return 3'b010;
            4'b1100:          return 3'b011;
            4'b0001:          return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] model_out(input int st, input logic [31:0] ins, input logic [3:0] f);
        logic [1:0] op, rs, imm;
        logic [3:0] cmd;
        logic       ce, wb, rd15;
        op   = ins[27:26];
        cmd  = ins[24:21];
        ce   = cond_ok(ins[31:28], f);
        rs   = {(op == 2'b01) && !ins[20], op == 2'b10};
        imm  = (op == 2'b11) ? 2'b00 : op;
        wb   = (cmd_kind(cmd) != 0) && (cmd != 4'b1010);
        rd15 = (ins[15:12] == 4'hF);
        case (st)
            F:   return pack(1, 0, 0, 1, 0, rs, 2'b01, 2'b10, 2'b10, imm, 3'b000);
            D:   return pack(0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 3'b000);
            MA:  return pack(0, 0, 0, 0, 0, rs, 2'b00, 2'b01, 2'b00, imm, 3'b000);
            MR:  return pack(0, 0, 0, 0, 1, rs, 2'b00, 2'b00, 2'b00, imm, 3'b000);
            MW:  return pack(0, ce, 0, 0, 1, rs, 2'b00, 2'b00, 2'b00, imm, 3'b000);
            MWB: return pack(ce && rd15, 0, ce, 0, 0, rs, 2'b00, 2'b00, 2'b01, imm, 3'b000);
            ER:  return pack(0, 0, 0, 0, 0, rs, 2'b00, 2'b00, 2'b00, imm, cmd_alu(cmd));
            EI:  return pack(0, 0, 0, 0, 0, rs, 2'b00, 2'b01, 2'b00, imm, cmd_alu(cmd));
            AWB: return pack(ce && wb && rd15, 0, ce && wb, 0, 0, rs, 2'b00, 2'b00, 2'b00, imm, 3'b000);
            BR:  return pack(ce, 0, 0, 0, 0, rs, 2'b10, 2'b01, 2'b10, imm, 3'b000);
            default: return 18'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, obs, e.vec);
        end
    endtask

    // Entered and left at a falling edge with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [31:0] ins, input logic [3:0] flg);
        int         seq[$];
        logic [3:0] cmd;
        exp_t       e;
        Instr    = ins;
        ALUFlags = flg;
        cmd      = ins[24:21];
        seq.push_back(F);
        seq.push_back(D);
        case (ins[27:26])
            2'b00: begin
                seq.push_back(ins[25] ? EI : ER);
                if (cmd != 4'b1010) seq.push_back(AWB);
            end
            2'b01: begin
                seq.push_back(MA);
                if (ins[20]) begin
                    seq.push_back(MR);
                    seq.push_back(MWB);
                end else begin
                    seq.push_back(MW);
                end
            end
            2'b10: seq.push_back(BR);
            default: ;
        endcase
        foreach (seq[i]) begin
            e.vec = model_out(seq[i], ins, m_flags);
            e.tag = $sformatf("%s_c%0d", name, i + 1);
            exp_q.push_back(e);
            if ((seq[i] == ER || seq[i] == EI) && cond_ok(ins[31:28], m_flags)
                && (ins[20] || cmd == 4'b1010)) begin
                if (cmd_kind(cmd) == 1) m_flags = flg;
                else if (cmd_kind(cmd) == 2) m_flags[3:2] = flg[3:2];
            end
        end
        foreach (seq[i]) begin
            #1 pop_check();
            @(negedge clk);
        end
    endtask

    initial begin
        exp_t e;
        reset    = 1'b0;
        Instr    = 32'h0;
        ALUFlags = 4'h0;
        m_flags  = 4'h0;
        @(negedge clk);
        @(negedge clk);
        e.vec = pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000);
        e.tag = "reset_hold_fetch";
        exp_q.push_back(e);
        #1 pop_check();
        reset = 1'b1;

        run_instr("add_imm",  32'hE2821005, 4'b0000);
        run_instr("cmp_z",    32'hE1510001, 4'b0100);
        run_instr("beq_t",    32'h0A000002, 4'b0000);
        run_instr("cmp_nz",   32'hE1510001, 4'b0000);
        run_instr("beq_nt",   32'h0A000002, 4'b0000);
        run_instr("ldr",      32'hE5921000, 4'b0000);
        run_instr("str",      32'hE5821000, 4'b0000);
        run_instr("add_pc",   32'hE28FF004, 4'b0000);
        run_instr("cond_nv",  32'hF2821005, 4'b0000);
        run_instr("cmp_c",    32'hE1510001, 4'b0010);
        run_instr("ands",     32'hE0110002, 4'b0100);
        run_instr("bhi_nt",   32'h8A000002, 4'b0000);
        run_instr("bcs_t",    32'h2A000002, 4'b0000);
        run_instr("beq_t2",   32'h0A000002, 4'b0000);
        run_instr("mov_nop",  32'hE1A01002, 4'b1111);
        run_instr("bcs_t2",   32'h2A000002, 4'b0000);
        run_instr("illegal",  32'hEC000000, 4'b0000);

        // LDR interrupted by reset during MEMRD
        Instr    = 32'hE5921000;
        ALUFlags = 4'b0000;
        e.vec = model_out(F, Instr, m_flags);  e.tag = "rst_ldr_c1"; exp_q.push_back(e);
        e.vec = model_out(D, Instr, m_flags);  e.tag = "rst_ldr_c2"; exp_q.push_back(e);
        e.vec = model_out(MA, Instr, m_flags); e.tag = "rst_ldr_c3"; exp_q.push_back(e);
        for (int i = 0; i < 3; i++) begin
            #1 pop_check();
            @(negedge clk);
        end
        reset = 1'b0;
        e.vec = pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
        e.tag = "rst_ldr_memrd_gated";
        exp_q.push_back(e);
        #1 pop_check();
        @(negedge clk);
        e.vec = pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 3'b000);
        e.tag = "rst_ldr_fetch_gated";
        exp_q.push_back(e);
        #1 pop_check();
        @(negedge clk);
        reset   = 1'b1;
        m_flags = 4'h0;

        run_instr("add_after_rst", 32'hE2821005, 4'b0000);
        run_instr("beq_after_rst", 32'h0A000002, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
